// File: rtl/aes_key_responder_pkg.sv
// Shared SoC package for the AES key responder.
// Provides the key count, key geometry and the key-word address offsets
// (relative to the key window base) used by the address decoder.
package aes_key_responder_pkg;

    localparam int unsigned NUM_KEYS  = 3;
    localparam int unsigned KEY_WORDS = 4;

    // Byte offset of key k, word w from the key window base.
    // Keys sit on 64-bit register slots 5..8, 14..17 and 18..21.
    function automatic logic [63:0] key_word_offset(input logic [1:0] k,
                                                    input logic [1:0] w);
        logic [63:0] slot;
        case (k)
            2'd0:    slot = 64'd5;
            2'd1:    slot = 64'd14;
            default: slot = 64'd18;
        endcase
        return (slot + 64'(w)) << 3;
    endfunction

endpackage

// File: rtl/aes_key_slot.sv
// One write-only AES key slot.
// Holds a 128-bit key (word 0 in bits [31:0]) plus a per-word written mask.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   we_i           write strobe for one 32-bit key word
//   word_idx_i     word index 0..3
//   wdata_i        word data
//   lock_i         when set, writes are ignored
//   key_o          current key value
//   key_valid_o    all four words have been written since reset
module aes_key_slot (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         we_i,
    input  logic [1:0]   word_idx_i,
    input  logic [31:0]  wdata_i,
    input  logic         lock_i,
    output logic [127:0] key_o,
    output logic         key_valid_o
);

    logic [3:0][31:0] key_q;
    logic [3:0]       mask_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            key_q  <= '0;
            mask_q <= '0;
        end else if (we_i && !lock_i) begin
            key_q[word_idx_i]  <= wdata_i;
            mask_q[word_idx_i] <= 1'b1;
        end
    end

    assign key_o       = key_q;
    assign key_valid_o = &mask_q;

endmodule

// File: rtl/aes_key_responder.sv
// AES key register responder.
// Single-port request/response slave exposing three write-only 128-bit keys
// and a sticky per-key lock register. One request completes every two
// cycles; the response follows the grant by one cycle.
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   req_i, we_i            request valid, 1 = write
//   addr_i, wdata_i        64-bit byte address, 32-bit write data
//   gnt_o                  request accepted this cycle
//   rvalid_o               one-cycle response pulse
//   rdata_o, err_o         response data / error, zero unless rvalid_o
//   key_o                  keys 0..2, word 0 in bits [31:0]
//   key_valid_o            per-key all-words-written flag
//   lock_o                 per-key lock state
module aes_key_responder
    import aes_key_responder_pkg::*;
#(
    parameter logic [63:0] AES0Base  = 64'hfff5200000,
    parameter logic [63:0] REGLKBase = 64'hfff5206000
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          req_i,
    input  logic                          we_i,
    input  logic [63:0]                   addr_i,
    input  logic [31:0]                   wdata_i,
    output logic                          gnt_o,
    output logic                          rvalid_o,
    output logic [31:0]                   rdata_o,
    output logic                          err_o,
    output logic [NUM_KEYS-1:0][127:0]    key_o,
    output logic [NUM_KEYS-1:0]           key_valid_o,
    output logic [NUM_KEYS-1:0]           lock_o
);

    typedef enum logic {IDLE, RESP} state_t;

    state_t              state_q, state_d;
    logic                grant;
    logic [NUM_KEYS-1:0] key_hit;
    logic [1:0]          word_idx;
    logic                lock_hit;
    logic [NUM_KEYS-1:0] lock_q;
    logic [31:0]         resp_rdata;
    logic                resp_err;
    logic                resp_q;
    logic [31:0]         rdata_q;
    logic                err_q;

    // Exact 64-bit address decode.
    always_comb begin
        key_hit  = '0;
        word_idx = '0;
        lock_hit = (addr_i == REGLKBase);
        for (int unsigned k = 0; k < NUM_KEYS; k++) begin
            for (int unsigned w = 0; w < KEY_WORDS; w++) begin
                if (addr_i == AES0Base + key_word_offset(2'(k), 2'(w))) begin
                    key_hit[k] = 1'b1;
                    word_idx   = 2'(w);
                end
            end
        end
    end

    // Response for the request being granted this cycle.
    always_comb begin
        resp_rdata = '0;
        resp_err   = 1'b0;
        if (lock_hit) begin
            if (!we_i) begin
                resp_rdata = {{(32 - NUM_KEYS){1'b0}}, lock_q};
            end
        end else if (|key_hit) begin
            resp_err = we_i && |(key_hit & lock_q);
        end else begin
            resp_err = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        case (state_q)
            IDLE: begin
                grant = req_i && !rst_i;
                if (grant) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q  <= '0;
            resp_q  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            resp_q  <= grant;
            rdata_q <= grant ? resp_rdata : '0;
            err_q   <= grant ? resp_err : 1'b0;
            if (grant && we_i && lock_hit) begin
                lock_q <= lock_q | wdata_i[NUM_KEYS-1:0];
            end
        end
    end

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_slot
        aes_key_slot u_slot (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .we_i        (grant && we_i && key_hit[k]),
            .word_idx_i  (word_idx),
            .wdata_i     (wdata_i),
            .lock_i      (lock_q[k]),
            .key_o       (key_o[k]),
            .key_valid_o (key_valid_o[k])
        );
    end

    // A reset arriving while a response is pending kills it in that cycle too.
    assign gnt_o    = grant;
    assign rvalid_o = resp_q && !rst_i;
    assign rdata_o  = rvalid_o ? rdata_q : '0;
    assign err_o    = rvalid_o && err_q;
    assign lock_o   = lock_q;

endmodule

// File: tb/tb_aes_key_responder.sv
module tb_aes_key_responder;

    localparam logic [63:0] AES0  = 64'hfff5200000;
    localparam logic [63:0] REGLK = 64'hfff5206000;

    logic              clk = 1'b0;
    logic              rst;
    logic              req;
    logic              we;
    logic [63:0]       addr;
    logic [31:0]       wdata;
    logic              gnt;
    logic              rvalid;
    logic [31:0]       rdata;
    logic              err;
    logic [2:0][127:0] key;
    logic [2:0]        key_valid;
    logic [2:0]        lock;

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] k0, k1, k2;

    aes_key_responder #(
        .AES0Base  (AES0),
        .REGLKBase (REGLK)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .we_i        (we),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .gnt_o       (gnt),
        .rvalid_o    (rvalid),
        .rdata_o     (rdata),
        .err_o       (err),
        .key_o       (key),
        .key_valid_o (key_valid),
        .lock_o      (lock)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One request: grant on the first cycle, response exactly one cycle later.
    task automatic txn(input string tag, input logic w, input logic [63:0] a,
                       input logic [31:0] d, input logic [31:0] exp_rdata,
                       input logic exp_err);
        @(posedge clk); #1;
        req = 1'b1; we = w; addr = a; wdata = d;
        @(negedge clk);
        chk({tag, ".gnt"}, 384'(gnt), 384'(1'b1));
        chk({tag, ".idle_rvalid"}, 384'(rvalid), 384'(1'b0));
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        chk({tag, ".rvalid"}, 384'(rvalid), 384'(1'b1));
        chk({tag, ".rdata"}, 384'(rdata), 384'(exp_rdata));
        chk({tag, ".err"}, 384'(err), 384'(exp_err));
    endtask

    initial begin
        rst = 1'b1; req = 1'b1; we = 1'b0; addr = REGLK; wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.gnt", 384'(gnt), 384'(1'b0));
        chk("rst.rvalid", 384'(rvalid), 384'(1'b0));
        chk("rst.rdata_err", 384'({rdata, err}), 384'(0));
        chk("rst.key", 384'(key), 384'(0));
        chk("rst.valid_lock", 384'({key_valid, lock}), 384'(0));
        @(posedge clk); #1;
        rst = 1'b0; req = 1'b0;

        // Key0 fill
        txn("k0w0", 1'b1, AES0 + 64'd40, 32'h11111111, 32'h0, 1'b0);
        txn("k0w1", 1'b1, AES0 + 64'd48, 32'h22222222, 32'h0, 1'b0);
        txn("k0w2", 1'b1, AES0 + 64'd56, 32'h33333333, 32'h0, 1'b0);
        chk("k0.partial_valid", 384'(key_valid), 384'(3'b000));
        txn("k0w3", 1'b1, AES0 + 64'd64, 32'h44444444, 32'h0, 1'b0);
        k0 = 128'h44444444_33333333_22222222_11111111;
        k1 = '0;
        k2 = '0;
        chk("k0.key", {k2, k1, key[0]}, {k2, k1, k0});
        chk("k0.valid", 384'(key_valid), 384'(3'b001));

        // Write-only readback
        txn("k0w0.deadbeef", 1'b1, AES0 + 64'd40, 32'hDEADBEEF, 32'h0, 1'b0);
        txn("k0w0.read", 1'b0, AES0 + 64'd40, 32'h0, 32'h0, 1'b0);
        k0 = 128'h44444444_33333333_22222222_DEADBEEF;
        chk("k0.after_rd", 384'(key), {k2, k1, k0});

        // Unmapped accesses
        txn("unmap.wr", 1'b1, AES0 + 64'd72, 32'hFFFFFFFF, 32'h0, 1'b1);
        txn("unmap.rd", 1'b0, AES0, 32'h0, 32'h0, 1'b1);
        txn("unmap.hi", 1'b1, (AES0 + 64'd40) ^ 64'h8000000000000000, 32'h0, 32'h0, 1'b1);
        txn("unmap.lk1", 1'b1, REGLK + 64'd8, 32'h7, 32'h0, 1'b1);
        chk("unmap.key", 384'(key), {k2, k1, k0});
        chk("unmap.lock", 384'(lock), 384'(3'b000));

        // Key2 fill, Key1 partial
        txn("k2w0", 1'b1, AES0 + 64'd144, 32'hA0A0A0A0, 32'h0, 1'b0);
        txn("k2w1", 1'b1, AES0 + 64'd152, 32'hA1A1A1A1, 32'h0, 1'b0);
        txn("k2w2", 1'b1, AES0 + 64'd160, 32'hA2A2A2A2, 32'h0, 1'b0);
        txn("k2w3", 1'b1, AES0 + 64'd168, 32'hA3A3A3A3, 32'h0, 1'b0);
        txn("k1w1", 1'b1, AES0 + 64'd120, 32'h55555555, 32'h0, 1'b0);
        k2 = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
        k1 = 128'h00000000_00000000_55555555_00000000;
        chk("k12.key", 384'(key), {k2, k1, k0});
        chk("k12.valid", 384'(key_valid), 384'(3'b101));

        // Lock key1
        txn("lk.wr2", 1'b1, REGLK, 32'h2, 32'h0, 1'b0);
        chk("lk.state", 384'(lock), 384'(3'b010));
        txn("k1w0.locked", 1'b1, AES0 + 64'd112, 32'h66666666, 32'h0, 1'b1);
        txn("k1w1.locked", 1'b1, AES0 + 64'd120, 32'h99999999, 32'h0, 1'b1);
        chk("k1.unchanged", 384'(key), {k2, k1, k0});
        txn("lk.rd", 1'b0, REGLK, 32'h0, 32'h2, 1'b0);
        txn("lk.wr0", 1'b1, REGLK, 32'h0, 32'h0, 1'b0);
        chk("lk.sticky", 384'(lock), 384'(3'b010));
        txn("k0w1.rewrite", 1'b1, AES0 + 64'd48, 32'h77777777, 32'h0, 1'b0);
        k0 = 128'h44444444_33333333_77777777_DEADBEEF;
        chk("rewrite.key", 384'(key), {k2, k1, k0});
        chk("rewrite.valid", 384'(key_valid), 384'(3'b101));

        // Back-to-back requests
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; addr = REGLK;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("b2b.gnt%0d", i), 384'(gnt), 384'(i % 2 == 0));
            chk($sformatf("b2b.rvalid%0d", i), 384'(rvalid), 384'(i % 2 == 1));
            chk($sformatf("b2b.rdata%0d", i), 384'(rdata), (i % 2 == 1) ? 384'(32'h2) : 384'(0));
        end
        @(posedge clk); #1;
        req = 1'b0;

        // Lock all, then reset during a pending response
        txn("lk.wr5", 1'b1, REGLK, 32'hFFFFFFF5, 32'h0, 1'b0);
        txn("lk.rd7", 1'b0, REGLK, 32'h0, 32'h7, 1'b0);
        txn("k2w0.locked", 1'b1, AES0 + 64'd144, 32'h0, 32'h0, 1'b1);
        chk("k2.unchanged", 384'(key), {k2, k1, k0});

        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; addr = REGLK;
        @(negedge clk);
        chk("rstresp.gnt", 384'(gnt), 384'(1'b1));
        @(posedge clk); #1;
        req = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rstresp.rvalid0", 384'(rvalid), 384'(1'b0));
        chk("rstresp.rdata_err0", 384'({rdata, err}), 384'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstresp.rvalid1", 384'(rvalid), 384'(1'b0));
        chk("rstresp.lock", 384'(lock), 384'(3'b000));
        chk("rstresp.valid", 384'(key_valid), 384'(3'b000));
        chk("rstresp.key", 384'(key), 384'(0));
        txn("post_rst.k0w0", 1'b1, AES0 + 64'd40, 32'h12345678, 32'h0, 1'b0);
        chk("post_rst.key", 384'(key), 384'(32'h12345678));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
